// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared counter type and saturating update for the branch predictor
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_ctr_t;

    localparam bp_ctr_t BP_CTR_RESET = WNT;
    localparam bp_ctr_t BP_CTR_ALLOC = WT;

    function automatic bp_ctr_t bp_ctr_next(input bp_ctr_t ctr, input logic taken);
        bp_ctr_t nxt;
        nxt = ctr;
        case (ctr)
            SNT: nxt = taken ? WNT : SNT;
            WNT: nxt = taken ? WT  : SNT;
            WT:  nxt = taken ? ST  : WNT;
            ST:  nxt = taken ? ST  : WT;
            default: nxt = ctr;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters driving next-PC
// Lookup is combinational from i_pc; training from execute lands on the next edge.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 16,
    localparam int IDX_W = $clog2(ENTRIES)
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_pc,
    output logic [31:0] o_pc_next,
    output logic        o_pred_taken,
    input  logic        i_upd_en,
    input  logic [31:0] i_upd_pc,
    input  logic        i_upd_taken,
    input  logic [31:0] i_upd_target
);

    localparam int TAG_W = 30 - IDX_W;

    logic [ENTRIES-1:0] valid_q;
    bp_ctr_t            ctr_q [ENTRIES];
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [29:0]        tgt_q [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [1:0]       lk_ctr;
    logic             lk_hit;

    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;

    logic unused_low_bits;
    assign unused_low_bits = ^{i_upd_pc[1:0], i_upd_target[1:0]};

    assign lk_idx = i_pc[IDX_W+1:2];
    assign lk_tag = i_pc[31:IDX_W+2];
    assign lk_ctr = ctr_q[lk_idx];
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    assign o_pred_taken = lk_hit && lk_ctr[1];
    assign o_pc_next    = o_pred_taken ? {tgt_q[lk_idx], 2'b00} : i_pc + 32'd4;

    assign up_idx = i_upd_pc[IDX_W+1:2];
    assign up_tag = i_upd_pc[31:IDX_W+2];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= BP_CTR_RESET;
            end
        end else if (i_upd_en) begin
            if (up_hit) begin
                ctr_q[up_idx] <= bp_ctr_next(ctr_q[up_idx], i_upd_taken);
            end else if (i_upd_taken) begin
                // Allocation evicts whatever lived at this index.
                valid_q[up_idx] <= 1'b1;
                ctr_q[up_idx]   <= BP_CTR_ALLOC;
            end
        end
    end

    // Tag rewrite on a taken hit is harmless: it stores the same value.
    always_ff @(posedge i_clk) begin
        if (!i_reset && i_upd_en && i_upd_taken) begin
            tag_q[up_idx] <= up_tag;
            tgt_q[up_idx] <= i_upd_target[31:2];
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed and randomized checks of branch_predictor against a table model
module tb_branch_predictor;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [31:0] i_pc = 32'h0;
    logic [31:0] o_pc_next;
    logic        o_pred_taken;
    logic        i_upd_en = 1'b0;
    logic [31:0] i_upd_pc = 32'h0;
    logic        i_upd_taken = 1'b0;
    logic [31:0] i_upd_target = 32'h0;

    int n_vec = 0;
    int n_err = 0;

    branch_predictor #(.ENTRIES(16)) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .i_pc(i_pc),
        .o_pc_next(o_pc_next),
        .o_pred_taken(o_pred_taken),
        .i_upd_en(i_upd_en),
        .i_upd_pc(i_upd_pc),
        .i_upd_taken(i_upd_taken),
        .i_upd_target(i_upd_target)
    );

    always #5 i_clk = ~i_clk;

    // Model: each slot remembers the full word address of its owner and a 0..3 count.
    bit        m_valid [16];
    bit [29:0] m_owner [16];
    bit [29:0] m_tgt   [16];
    int        m_cnt   [16];

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_cnt[i]   = 1;
        end
    endtask

    always @(posedge i_reset) model_clear();

    always @(posedge i_clk) begin
        int k;
        k = int'(i_upd_pc[5:2]);
        if (i_reset) begin
            model_clear();
        end else if (i_upd_en) begin
            if (m_valid[k] && m_owner[k] == i_upd_pc[31:2]) begin
                if (i_upd_taken) begin
                    m_cnt[k] = (m_cnt[k] < 3) ? m_cnt[k] + 1 : 3;
                    m_tgt[k] = i_upd_target[31:2];
                end else begin
                    m_cnt[k] = (m_cnt[k] > 0) ? m_cnt[k] - 1 : 0;
                end
            end else if (i_upd_taken) begin
                m_valid[k] = 1'b1;
                m_owner[k] = i_upd_pc[31:2];
                m_tgt[k]   = i_upd_target[31:2];
                m_cnt[k]   = 2;
            end
        end
    end

    task automatic check(input string name, input logic got_t, input logic [31:0] got_n,
                         input logic want_t, input logic [31:0] want_n);
        n_vec++;
        if (got_t !== want_t || got_n !== want_n) begin
            n_err++;
            $display("FAIL %s: pc=%h got taken=%0b next=%h, want taken=%0b next=%h",
                     name, i_pc, got_t, got_n, want_t, want_n);
        end
    endtask

    always @(negedge i_clk) begin
        int  k;
        bit  pt;
        bit [31:0] nx;
        k  = int'(i_pc[5:2]);
        pt = m_valid[k] && m_owner[k] == i_pc[31:2] && m_cnt[k] >= 2;
        nx = pt ? {m_tgt[k], 2'b00} : i_pc + 32'd4;
        check("model", o_pred_taken, o_pc_next, pt, nx);
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        i_upd_en     = 1'b1;
        i_upd_pc     = pc;
        i_upd_taken  = taken;
        i_upd_target = tgt;
        step();
        i_upd_en = 1'b0;
    endtask

    task automatic look(input string name, input logic [31:0] pc,
                        input logic want_t, input logic [31:0] want_n);
        i_pc = pc;
        #1;
        check(name, o_pred_taken, o_pc_next, want_t, want_n);
    endtask

    initial begin
        logic [31:0] pool [8];

        // Scenario 1: in reset
        #1;
        look("rst_pc0", 32'h0, 1'b0, 32'h4);
        look("rst_pc100", 32'h100, 1'b0, 32'h104);
        look("rst_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);
        step();
        step();
        i_reset = 1'b0;
        step();
        look("post_rst_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

        // Scenario 2
        upd(32'h100, 1'b1, 32'h200);
        look("alloc_hit", 32'h100, 1'b1, 32'h200);
        look("alloc_neighbor", 32'h104, 1'b0, 32'h108);

        // Scenario 3: counter walk
        upd(32'h100, 1'b0, 32'h0);
        look("ctr_wnt", 32'h100, 1'b0, 32'h104);
        upd(32'h100, 1'b1, 32'h240);
        look("ctr_wt_newtgt", 32'h100, 1'b1, 32'h240);
        upd(32'h100, 1'b1, 32'h200);
        upd(32'h100, 1'b1, 32'h280);
        look("ctr_st_sat", 32'h100, 1'b1, 32'h280);
        upd(32'h100, 1'b0, 32'h0);
        look("ctr_st_to_wt", 32'h100, 1'b1, 32'h280);
        upd(32'h100, 1'b0, 32'h0);
        look("ctr_wt_to_wnt", 32'h100, 1'b0, 32'h104);

        // Scenario 4: aliasing on index 0
        upd(32'h100, 1'b1, 32'h200);
        upd(32'h140, 1'b1, 32'h300);
        look("alias_evicted", 32'h100, 1'b0, 32'h104);
        look("alias_new", 32'h140, 1'b1, 32'h300);
        upd(32'h180, 1'b0, 32'h0);
        look("alias_nt_miss", 32'h140, 1'b1, 32'h300);
        upd(32'h140, 1'b0, 32'h0);
        look("alias_alloc_wt", 32'h140, 1'b0, 32'h144);

        // Scenario 5: same-cycle lookup and update, empty table
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        step();
        i_upd_en = 1'b1; i_upd_pc = 32'h100; i_upd_taken = 1'b1; i_upd_target = 32'h200;
        look("same_cycle_old", 32'h100, 1'b0, 32'h104);
        step();
        i_upd_en = 1'b0;
        look("same_cycle_new", 32'h100, 1'b1, 32'h200);

        // Scenario 6: async reset mid-cycle, update edge under reset discarded
        upd(32'h10, 1'b1, 32'h500);
        upd(32'h24, 1'b1, 32'h600);
        look("pop_a", 32'h10, 1'b1, 32'h500);
        #1;
        i_reset = 1'b1;
        look("async_a", 32'h10, 1'b0, 32'h14);
        look("async_b", 32'h24, 1'b0, 32'h28);
        upd(32'h30, 1'b1, 32'h800);
        i_reset = 1'b0;
        look("upd_in_reset", 32'h30, 1'b0, 32'h34);
        upd(32'h10, 1'b1, 32'h700);
        look("realloc", 32'h10, 1'b1, 32'h700);
        upd(32'h10, 1'b0, 32'h0);
        look("realloc_wnt", 32'h10, 1'b0, 32'h14);

        // Randomized phase over a small aliasing PC pool
        for (int i = 0; i < 8; i++) begin
            pool[i] = {$urandom_range(0, 2) == 0 ? 26'h3FF_FFFF : 26'($urandom_range(0, 3)),
                       4'($urandom_range(0, 15)), 2'b00};
        end
        for (int c = 0; c < 3000; c++) begin
            step();
            i_reset      = ($urandom_range(0, 199) == 0);
            i_pc         = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
            i_upd_en     = $urandom_range(0, 1) == 1;
            i_upd_pc     = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
            i_upd_taken  = $urandom_range(0, 2) != 0;
            i_upd_target = $urandom;
        end
        step();
        i_reset  = 1'b0;
        i_upd_en = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
